game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_game_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Control FSM for a 3x3 sliding-tile game: accepts one move at a time, commits the
// datapath result, spawns a new tile by scanning for the target blank, then checks win/lose.
module game_ctrl #(
  parameter logic [2:0] WIN_TILE = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_r,
  input  logic        btn_l,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        restart,
  input  logic [15:0] rand_count,
  input  logic [26:0] new_grid_in,
  input  logic [3:0]  blank_in,
  input  logic        lose_in,
  output logic [26:0] grid,
  output logic        dir_r,
  output logic        dir_l,
  output logic        dir_u,
  output logic        dir_d,
  output logic        busy,
  output logic        win,
  output logic        game_over,
  output logic [15:0] move_count
);

  localparam int unsigned CELL_W = 3;
  localparam int unsigned CELLS  = 9;
  localparam int unsigned GRID_W = CELL_W * CELLS;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [2:0] {
    S_INIT1, S_INIT2, S_IDLE, S_MOVE, S_SCAN, S_CHECK, S_OVER
  } state_t;

  typedef enum logic [1:0] {
    SRC_INIT1, SRC_INIT2, SRC_MOVE
  } src_t;

  state_t             r_state, r_state_nxt;
  src_t               r_src, r_src_nxt;
  logic [GRID_W-1:0]  r_grid, r_grid_nxt;
  logic [3:0]         r_dir, r_dir_nxt;
  logic               r_busy, r_busy_nxt;
  logic               r_win, r_win_nxt;
  logic               r_over, r_over_nxt;
  logic [CNT_W-1:0]   r_moves, r_moves_nxt;
  logic [IDX_W-1:0]   r_target, r_target_nxt;
  logic [CELL_W-1:0]  r_val, r_val_nxt;
  logic [IDX_W-1:0]   r_idx, r_idx_nxt;
  logic [IDX_W-1:0]   r_seen, r_seen_nxt;

  logic [3:0]         w_btn;
  logic               w_one_btn;
  logic [CELL_W-1:0]  w_spawn_val;
  logic [7:0]         w_div;
  logic [IDX_W-1:0]   w_tgt_move;
  logic [IDX_W-1:0]   w_tgt_init1;
  logic [IDX_W-1:0]   w_tgt_init2;
  logic [CELL_W-1:0]  w_cell;
  logic               w_has_win;
  logic               w_scan_done;
  logic               w_unused_rand;

  assign w_btn         = {btn_r, btn_l, btn_u, btn_d};
  assign w_one_btn     = $onehot(w_btn);
  assign w_spawn_val   = (rand_count[11:8] == 4'd0) ? 3'd2 : 3'd1;
  assign w_div         = (blank_in == 4'd0) ? 8'd1 : {4'd0, blank_in};
  assign w_tgt_move    = IDX_W'(rand_count[7:0] % w_div);
  assign w_tgt_init1   = IDX_W'(rand_count[7:0] % 8'd9);
  assign w_tgt_init2   = IDX_W'(rand_count[7:0] % 8'd8);
  assign w_unused_rand = ^rand_count[15:12];

  // Cell under the scan pointer and win-tile detection on the registered board
  always_comb begin
    w_cell    = '0;
    w_has_win = 1'b0;
    for (int k = 0; k < CELLS; k++) begin
      if (r_idx == IDX_W'(k)) w_cell = r_grid[CELL_W*k +: CELL_W];
      if (r_grid[CELL_W*k +: CELL_W] == WIN_TILE) w_has_win = 1'b1;
    end
  end

  always_comb begin
    r_state_nxt  = r_state;
    r_src_nxt    = r_src;
    r_grid_nxt   = r_grid;
    r_dir_nxt    = 4'd0;
    r_win_nxt    = r_win;
    r_over_nxt   = r_over;
    r_moves_nxt  = r_moves;
    r_target_nxt = r_target;
    r_val_nxt    = r_val;
    r_idx_nxt    = r_idx;
    r_seen_nxt   = r_seen;
    w_scan_done  = 1'b0;

    case (r_state)
      S_INIT1: begin
        r_target_nxt = w_tgt_init1;
        r_val_nxt    = w_spawn_val;
        r_idx_nxt    = '0;
        r_seen_nxt   = '0;
        r_src_nxt    = SRC_INIT1;
        r_state_nxt  = S_SCAN;
      end
      S_INIT2: begin
        r_target_nxt = w_tgt_init2;
        r_val_nxt    = w_spawn_val;
        r_idx_nxt    = '0;
        r_seen_nxt   = '0;
        r_src_nxt    = SRC_INIT2;
        r_state_nxt  = S_SCAN;
      end
      S_IDLE: begin
        if (restart) begin
          r_grid_nxt  = '0;
          r_win_nxt   = 1'b0;
          r_over_nxt  = 1'b0;
          r_moves_nxt = '0;
          r_state_nxt = S_INIT1;
        end else if (w_one_btn) begin
          r_dir_nxt   = w_btn;
          r_state_nxt = S_MOVE;
        end
      end
      S_MOVE: begin
        if (new_grid_in == r_grid) begin
          r_state_nxt = S_IDLE;
        end else begin
          r_grid_nxt   = new_grid_in;
          r_moves_nxt  = (r_moves == '1) ? r_moves : r_moves + CNT_W'(1);
          r_target_nxt = w_tgt_move;
          r_val_nxt    = w_spawn_val;
          r_idx_nxt    = '0;
          r_seen_nxt   = '0;
          r_src_nxt    = SRC_MOVE;
          r_state_nxt  = (blank_in == 4'd0) ? S_CHECK : S_SCAN;
        end
      end
      S_SCAN: begin
        // Place the spawn tile in the target-th blank cell, scanning cell 0 upward
        if (w_cell == '0) begin
          if (r_seen == r_target) begin
            for (int k = 0; k < CELLS; k++) begin
              if (r_idx == IDX_W'(k)) r_grid_nxt[CELL_W*k +: CELL_W] = r_val;
            end
            w_scan_done = 1'b1;
          end else begin
            r_seen_nxt = r_seen + IDX_W'(1);
          end
        end
        if (r_idx == IDX_W'(CELLS - 1)) w_scan_done = 1'b1;
        else                            r_idx_nxt   = r_idx + IDX_W'(1);
        if (w_scan_done) begin
          case (r_src)
            SRC_INIT1: r_state_nxt = S_INIT2;
            SRC_INIT2: r_state_nxt = S_IDLE;
            default:   r_state_nxt = S_CHECK;
          endcase
        end
      end
      S_CHECK: begin
        if (w_has_win) begin
          r_win_nxt   = 1'b1;
          r_state_nxt = S_OVER;
        end else if (lose_in) begin
          r_over_nxt  = 1'b1;
          r_state_nxt = S_OVER;
        end else begin
          r_state_nxt = S_IDLE;
        end
      end
      S_OVER: begin
        if (restart) begin
          r_grid_nxt  = '0;
          r_win_nxt   = 1'b0;
          r_over_nxt  = 1'b0;
          r_moves_nxt = '0;
          r_state_nxt = S_INIT1;
        end
      end
      default: r_state_nxt = S_INIT1;
    endcase

    r_busy_nxt = !((r_state_nxt == S_IDLE) || (r_state_nxt == S_OVER));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_INIT1;
      r_src    <= SRC_INIT1;
      r_grid   <= '0;
      r_dir    <= 4'd0;
      r_busy   <= 1'b1;
      r_win    <= 1'b0;
      r_over   <= 1'b0;
      r_moves  <= '0;
      r_target <= '0;
      r_val    <= '0;
      r_idx    <= '0;
      r_seen   <= '0;
    end else begin
      r_state  <= r_state_nxt;
      r_src    <= r_src_nxt;
      r_grid   <= r_grid_nxt;
      r_dir    <= r_dir_nxt;
      r_busy   <= r_busy_nxt;
      r_win    <= r_win_nxt;
      r_over   <= r_over_nxt;
      r_moves  <= r_moves_nxt;
      r_target <= r_target_nxt;
      r_val    <= r_val_nxt;
      r_idx    <= r_idx_nxt;
      r_seen   <= r_seen_nxt;
    end
  end

  assign grid       = r_grid;
  assign dir_r      = r_dir[3];
  assign dir_l      = r_dir[2];
  assign dir_u      = r_dir[1];
  assign dir_d      = r_dir[0];
  assign busy       = r_busy;
  assign win        = r_win;
  assign game_over  = r_over;
  assign move_count = r_moves;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: init spawn, no-op and committed moves, win/lose,
// restart gating, dropped buttons and reset mid-scan.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_r = 1'b0, btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] rand_count = 16'h0100;
  logic [26:0] new_grid_in = '0;
  logic [3:0]  blank_in = 4'd0;
  logic        lose_in = 1'b0;
  logic [26:0] grid;
  logic        dir_r, dir_l, dir_u, dir_d;
  logic        busy, win, game_over;
  logic [15:0] move_count;

  int tests = 0;
  int fails = 0;

  game_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
    .restart(restart), .rand_count(rand_count),
    .new_grid_in(new_grid_in), .blank_in(blank_in), .lose_in(lose_in),
    .grid(grid), .dir_r(dir_r), .dir_l(dir_l), .dir_u(dir_u), .dir_d(dir_d),
    .busy(busy), .win(win), .game_over(game_over), .move_count(move_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < budget);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_dirs(input string tag);
    chk(tag, 32'({dir_r, dir_l, dir_u, dir_d}), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_grid", 32'(grid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_moves", 32'(move_count), 32'd0);
    chk("rst_flags", 32'({win, game_over}), 32'd0);
    chk_dirs("rst_dirs");

    // Initial spawn: target 0, value 1 twice -> cells 0 and 1
    rst = 1'b0;
    wait_idle("init", 12);
    chk("init_grid", 32'(grid), 32'h0000009);
    chk("init_moves", 32'(move_count), 32'd0);

    // Move that does not change the board
    new_grid_in = 27'h0000009;
    btn_l = 1'b1;
    tick();
    btn_l = 1'b0;
    chk("noop_dir_l_hi", 32'(dir_l), 32'd1);
    chk("noop_busy", 32'(busy), 32'd1);
    tick();
    chk("noop_dir_l_lo", 32'(dir_l), 32'd0);
    chk("noop_back_idle", 32'(busy), 32'd0);
    chk("noop_grid", 32'(grid), 32'h0000009);
    chk("noop_moves", 32'(move_count), 32'd0);

    // Committed move, spawn at 4th blank (cell 4)
    new_grid_in = 27'h0000008;
    blank_in = 4'd8;
    rand_count = 16'h0103;
    btn_r = 1'b1;
    tick();
    btn_r = 1'b0;
    chk("mv_dir_r", 32'(dir_r), 32'd1);
    wait_idle("mv", 20);
    chk("mv_grid", 32'(grid), 32'h0001008);
    chk("mv_moves", 32'(move_count), 32'd1);
    chk("mv_flags", 32'({win, game_over}), 32'd0);

    // Win tile in cell 2; lose_in also high to confirm win priority
    new_grid_in = 27'h00011C8;
    blank_in = 4'd6;
    rand_count = 16'h0100;
    lose_in = 1'b1;
    btn_d = 1'b1;
    tick();
    btn_d = 1'b0;
    chk("win_dir_d", 32'(dir_d), 32'd1);
    wait_idle("win", 20);
    chk("win_flag", 32'(win), 32'd1);
    chk("win_no_lose", 32'(game_over), 32'd0);
    chk("win_grid", 32'(grid), 32'h00011C9);
    chk("win_moves", 32'(move_count), 32'd2);

    // Buttons in OVER are ignored
    new_grid_in = 27'h0000001;
    btn_u = 1'b1;
    tick();
    btn_u = 1'b0;
    chk_dirs("over_dirs");
    chk("over_busy", 32'(busy), 32'd0);
    tick();
    chk("over_grid", 32'(grid), 32'h00011C9);
    chk("over_win_hold", 32'(win), 32'd1);

    // Restart from OVER
    lose_in = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_grid", 32'(grid), 32'd0);
    chk("rs_flags", 32'({win, game_over}), 32'd0);
    chk("rs_moves", 32'(move_count), 32'd0);
    wait_idle("rs", 12);
    chk("rs_init_grid", 32'(grid), 32'h0000009);

    // Two buttons together are ignored
    new_grid_in = 27'h0000008;
    btn_r = 1'b1;
    btn_u = 1'b1;
    tick();
    btn_r = 1'b0;
    btn_u = 1'b0;
    chk_dirs("dual_dirs");
    chk("dual_busy", 32'(busy), 32'd0);

    // Lose path; restart and button while busy are dropped
    new_grid_in = 27'h0000008;
    blank_in = 4'd8;
    rand_count = 16'h0103;
    lose_in = 1'b1;
    btn_r = 1'b1;
    tick();
    btn_r = 1'b0;
    chk("lose_dir_r", 32'(dir_r), 32'd1);
    restart = 1'b1;
    btn_l = 1'b1;
    tick();
    restart = 1'b0;
    btn_l = 1'b0;
    chk_dirs("busy_btn_drop");
    wait_idle("lose", 20);
    chk("lose_flag", 32'(game_over), 32'd1);
    chk("lose_no_win", 32'(win), 32'd0);
    chk("lose_moves", 32'(move_count), 32'd1);
    chk("lose_grid", 32'(grid), 32'h0001008);

    // Reset mid-scan
    lose_in = 1'b0;
    rand_count = 16'h0100;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    wait_idle("rs2", 12);
    chk("rs2_grid", 32'(grid), 32'h0000009);
    rand_count = 16'h0103;
    btn_r = 1'b1;
    tick();
    btn_r = 1'b0;
    tick();
    tick();
    chk("scan_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_grid", 32'(grid), 32'd0);
    chk("mid_rst_moves", 32'(move_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    chk_dirs("mid_rst_dirs");
    rand_count = 16'h0100;
    tick();
    rst = 1'b0;
    wait_idle("reinit", 12);
    chk("reinit_grid", 32'(grid), 32'h0000009);
    chk("reinit_moves", 32'(move_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
